// File: rtl/pueo_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pueo_sched_pkg                                                       |
// | Shared types and constants for the PUEO run/trigger scheduler.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package pueo_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RST   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } sched_state_t;

  localparam int RST_LEN   = 4;
  localparam int EVCNT_W   = 32;
  localparam int DROPCNT_W = 16;
  localparam int RST_CNT_W = $clog2(RST_LEN);

endpackage
`default_nettype wire

// File: rtl/pueo_buf_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pueo_buf_tracker                                                     |
// | Outstanding-event counter with full/empty flags and sticky underflow.|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module pueo_buf_tracker #(
  parameter int NBUF  = 4,
  parameter int OCC_W = $clog2(NBUF + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic             i_clr_underflow,
  output logic [OCC_W-1:0] o_occupancy,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_underflow
);

  logic [OCC_W-1:0] r_occ;
  logic             r_underflow;
  logic             w_empty;

  assign w_empty = (r_occ == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_occ       <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (i_inc && !i_dec) begin
        r_occ <= r_occ + 1'b1;
      end else if (!i_inc && i_dec && !w_empty) begin
        r_occ <= r_occ - 1'b1;
      end
      // A done that coincides with a new acceptance never underflows.
      r_underflow <= (r_underflow & ~i_clr_underflow) | (i_dec & ~i_inc & w_empty);
    end
  end

  assign o_occupancy = r_occ;
  assign o_full      = (r_occ == OCC_W'(NBUF));
  assign o_empty     = w_empty;
  assign o_underflow = r_underflow;

endmodule
`default_nettype wire

// File: rtl/pueo_trig_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pueo_trig_scheduler                                                  |
// | Run sequencer and trigger gate (occupancy + holdoff) in ifclk domain.|
// | Holdoff gate built only when PUEO_SCHED_HOLDOFF_EN is defined.       |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module pueo_trig_scheduler
  import pueo_sched_pkg::*;
#(
  parameter int NBUF    = 4,
  parameter int HOLDOFF = 16,
  parameter int TIME_W  = 16
) (
  input  logic                       ifclk_i,
  input  logic                       ifclk_rst_i,
  input  logic                       run_start_i,
  input  logic                       run_stop_i,
  output logic                       run_rst_o,
  output logic                       running_o,
  output logic                       busy_o,
  input  logic [TIME_W-1:0]          trig_req_time_i,
  input  logic                       trig_req_valid_i,
  output logic [TIME_W-1:0]          trig_time_o,
  output logic                       trig_time_valid_o,
  input  logic                       readout_done_i,
  output logic [$clog2(NBUF+1)-1:0]  occupancy_o,
  output logic [EVCNT_W-1:0]         event_count_o,
  output logic [DROPCNT_W-1:0]       drop_count_o,
  output logic                       underflow_o
);

  localparam int OCC_W = $clog2(NBUF + 1);

  sched_state_t          r_state;
  sched_state_t          w_state_nxt;
  logic [RST_CNT_W-1:0]  r_rst_cnt;
  logic                  w_enter_rst;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_holdoff_ok;
  logic [TIME_W-1:0]     r_trig_time;
  logic                  r_trig_valid;
  logic [EVCNT_W-1:0]    r_event_count;
  logic [DROPCNT_W-1:0]  r_drop_count;
  logic                  w_unused_time_lsb;

  assign w_unused_time_lsb = &{1'b0, trig_req_time_i[1:0]};

  always_ff @(posedge ifclk_i) begin
    if (ifclk_rst_i) begin
      r_state   <= IDLE;
      r_rst_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rst_cnt <= (r_state == RST) ? r_rst_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    run_rst_o   = 1'b0;
    running_o   = 1'b0;
    busy_o      = 1'b1;
    case (r_state)
      IDLE: begin
        busy_o = 1'b0;
        if (run_start_i) w_state_nxt = RST;
      end
      RST: begin
        run_rst_o = 1'b1;
        if (r_rst_cnt == RST_CNT_W'(RST_LEN - 1)) w_state_nxt = RUN;
      end
      RUN: begin
        running_o = 1'b1;
        if (run_stop_i) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        // Registered occupancy: a stop at zero still spends one cycle here.
        if (w_empty) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_enter_rst = (r_state == IDLE) && run_start_i;
  assign w_accept    = (r_state == RUN) && trig_req_valid_i && !w_full && w_holdoff_ok;
  assign w_drop      = (r_state == RUN) && trig_req_valid_i && !w_accept;

`ifdef PUEO_SCHED_HOLDOFF_EN
  localparam int HO_W = $clog2(HOLDOFF + 1);
  logic [HO_W-1:0] r_holdoff;

  always_ff @(posedge ifclk_i) begin
    if (ifclk_rst_i) begin
      r_holdoff <= '0;
    end else if (w_accept) begin
      r_holdoff <= HO_W'(HOLDOFF - 1);
    end else if (r_holdoff != '0) begin
      r_holdoff <= r_holdoff - 1'b1;
    end
  end

  assign w_holdoff_ok = (r_holdoff == '0);
`else
  // HOLDOFF has no effect in this build; only occupancy gates triggers.
  assign w_holdoff_ok = 1'b1 | (HOLDOFF < 0);
`endif

  always_ff @(posedge ifclk_i) begin
    if (ifclk_rst_i) begin
      r_trig_valid  <= 1'b0;
      r_trig_time   <= '0;
      r_event_count <= '0;
      r_drop_count  <= '0;
    end else begin
      r_trig_valid <= w_accept;
      if (w_accept) r_trig_time <= {trig_req_time_i[TIME_W-1:2], 2'b00};
      if (w_enter_rst) begin
        r_event_count <= '0;
        r_drop_count  <= '0;
      end else begin
        if (w_accept) r_event_count <= r_event_count + 1'b1;
        if (w_drop && (r_drop_count != '1)) r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

  pueo_buf_tracker #(
    .NBUF  (NBUF),
    .OCC_W (OCC_W)
  ) u_buf_tracker (
    .clk             (ifclk_i),
    .rst             (ifclk_rst_i),
    .i_inc           (w_accept),
    .i_dec           (readout_done_i),
    .i_clr_underflow (w_enter_rst),
    .o_occupancy     (occupancy_o),
    .o_full          (w_full),
    .o_empty         (w_empty),
    .o_underflow     (underflow_o)
  );

  assign trig_time_o       = r_trig_time;
  assign trig_time_valid_o = r_trig_valid;
  assign event_count_o     = r_event_count;
  assign drop_count_o      = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_pueo_trig_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pueo_trig_scheduler                                               |
// | Directed + random bench against a cycle-number based reference model.|
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_pueo_trig_scheduler;

  localparam int NBUF    = 4;
  localparam int HOLDOFF = 16;
  localparam int TIME_W  = 16;
  localparam int OCC_W   = $clog2(NBUF + 1);
  localparam int M_IDLE  = 0;
  localparam int M_RST   = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;

  logic              ifclk_i = 1'b0;
  logic              ifclk_rst_i;
  logic              run_start_i;
  logic              run_stop_i;
  logic              run_rst_o;
  logic              running_o;
  logic              busy_o;
  logic [TIME_W-1:0] trig_req_time_i;
  logic              trig_req_valid_i;
  logic [TIME_W-1:0] trig_time_o;
  logic              trig_time_valid_o;
  logic              readout_done_i;
  logic [OCC_W-1:0]  occupancy_o;
  logic [31:0]       event_count_o;
  logic [15:0]       drop_count_o;
  logic              underflow_o;

  pueo_trig_scheduler #(
    .NBUF    (NBUF),
    .HOLDOFF (HOLDOFF),
    .TIME_W  (TIME_W)
  ) dut (
    .ifclk_i           (ifclk_i),
    .ifclk_rst_i       (ifclk_rst_i),
    .run_start_i       (run_start_i),
    .run_stop_i        (run_stop_i),
    .run_rst_o         (run_rst_o),
    .running_o         (running_o),
    .busy_o            (busy_o),
    .trig_req_time_i   (trig_req_time_i),
    .trig_req_valid_i  (trig_req_valid_i),
    .trig_time_o       (trig_time_o),
    .trig_time_valid_o (trig_time_valid_o),
    .readout_done_i    (readout_done_i),
    .occupancy_o       (occupancy_o),
    .event_count_o     (event_count_o),
    .drop_count_o      (drop_count_o),
    .underflow_o       (underflow_o)
  );

  always #5 ifclk_i = ~ifclk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: run phase, remaining reset cycles, cycle timestamps.
  int                m_mode;
  int                m_rst_left;
  int                m_occ;
  longint            m_cycle = 0;
  longint            m_last_acc;
  bit                m_acc_seen;
  logic [31:0]       m_evt;
  int                m_drop;
  bit                m_uf;
  bit                m_tv;
  logic [TIME_W-1:0] m_tt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("run_rst",   64'(run_rst_o),         64'(m_mode == M_RST));
    chk("running",   64'(running_o),         64'(m_mode == M_RUN));
    chk("busy",      64'(busy_o),            64'(m_mode != M_IDLE));
    chk("trig_vld",  64'(trig_time_valid_o), 64'(m_tv));
    chk("trig_time", 64'(trig_time_o),       64'(m_tt));
    chk("occupancy", 64'(occupancy_o),       64'(m_occ));
    chk("evt_cnt",   64'(event_count_o),     64'(m_evt));
    chk("drop_cnt",  64'(drop_count_o),      64'(m_drop));
    chk("underflow", 64'(underflow_o),       64'(m_uf));
  endtask

  task automatic do_reset();
    @(negedge ifclk_i);
    ifclk_rst_i      = 1'b1;
    run_start_i      = 1'b0;
    run_stop_i       = 1'b0;
    trig_req_valid_i = 1'b1;
    trig_req_time_i  = 16'h1234;
    readout_done_i   = 1'b1;
    @(posedge ifclk_i);
    #1;
    m_cycle++;
    m_mode = M_IDLE; m_rst_left = 0; m_occ = 0; m_acc_seen = 1'b0;
    m_evt = '0; m_drop = 0; m_uf = 1'b0; m_tv = 1'b0; m_tt = '0;
    chk_all();
  endtask

  task automatic step(input bit st, input bit sp, input bit v,
                      input logic [TIME_W-1:0] t, input bit dn);
    bit acc, drp, ho_ok;
    int occ_pre;
    @(negedge ifclk_i);
    ifclk_rst_i      = 1'b0;
    run_start_i      = st;
    run_stop_i       = sp;
    trig_req_valid_i = v;
    trig_req_time_i  = t;
    readout_done_i   = dn;
    ho_ok = 1'b1;
`ifdef PUEO_SCHED_HOLDOFF_EN
    ho_ok = !m_acc_seen || ((m_cycle - m_last_acc) >= HOLDOFF);
`endif
    acc = (m_mode == M_RUN) && v && (m_occ < NBUF) && ho_ok;
    drp = (m_mode == M_RUN) && v && !acc;
    occ_pre = m_occ;
    m_tv = acc;
    if (acc) begin
      m_tt = {t[TIME_W-1:2], 2'b00};
      m_evt = m_evt + 1;
      m_last_acc = m_cycle;
      m_acc_seen = 1'b1;
    end
    if (drp && m_drop < 65535) m_drop++;
    case (m_mode)
      M_IDLE: if (st) begin
        m_mode = M_RST; m_rst_left = 4; m_evt = '0; m_drop = 0; m_uf = 1'b0;
      end
      M_RST: begin
        m_rst_left--;
        if (m_rst_left == 0) m_mode = M_RUN;
      end
      M_RUN:   if (sp) m_mode = M_DRAIN;
      default: if (occ_pre == 0) m_mode = M_IDLE;
    endcase
    if (acc && !dn) m_occ++;
    else if (dn && !acc) begin
      if (m_occ == 0) m_uf = 1'b1;
      else m_occ--;
    end
    m_cycle++;
    @(posedge ifclk_i);
    #1;
    chk_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0);
  endtask

  initial begin
    ifclk_rst_i = 1'b1; run_start_i = 1'b0; run_stop_i = 1'b0;
    trig_req_valid_i = 1'b0; trig_req_time_i = '0; readout_done_i = 1'b0;

    do_reset();
    chk("rst_busy", 64'(busy_o), 64'd0);

    // Start: run_rst for 4 cycles, then running.
    step(1, 0, 0, '0, 0);
    chk("run_rst_rise", 64'(run_rst_o), 64'd1);
    idle(3);
    chk("run_rst_4th", 64'(run_rst_o), 64'd1);
    idle(1);
    chk("running_rise", 64'(running_o), 64'd1);
    chk("evt_zero", 64'(event_count_o), 64'd0);

    // Alignment of trigger time.
    step(0, 0, 1, 16'd14, 0);
    chk("t14_vld", 64'(trig_time_valid_o), 64'd1);
    chk("t14_time", 64'(trig_time_o), 64'd12);
    chk("t14_occ", 64'(occupancy_o), 64'd1);
    chk("t14_evt", 64'(event_count_o), 64'd1);

    // Holdoff window: requests at t+15 and t+16.
    idle(14);
    step(0, 0, 1, 16'd101, 0);
`ifdef PUEO_SCHED_HOLDOFF_EN
    chk("ho_t15_drop", 64'(drop_count_o), 64'd1);
`else
    chk("ho_t15_drop", 64'(drop_count_o), 64'd0);
`endif
    step(0, 0, 1, 16'd203, 0);
    chk("ho_t16_vld", 64'(trig_time_valid_o), 64'd1);
    chk("ho_t16_time", 64'(trig_time_o), 64'd200);

    // Drain buffers, then fill past NBUF.
    while (m_occ > 0) step(0, 0, 0, '0, 1);
    for (int k = 0; k < 5; k++) begin
      idle(19);
      step(0, 0, 1, TIME_W'(k * 40 + 7), 0);
    end
    chk("full_occ", 64'(occupancy_o), 64'd4);
    chk("full_vld", 64'(trig_time_valid_o), 64'd0);
    step(0, 0, 0, '0, 1);
    idle(20);
    step(0, 0, 1, 16'd77, 1);
    chk("acc_done_occ", 64'(occupancy_o), 64'd3);
    chk("acc_done_vld", 64'(trig_time_valid_o), 64'd1);

    // Stop with occupancy 2, request while draining.
    step(0, 0, 0, '0, 1);
    step(0, 1, 0, '0, 0);
    chk("drain_busy", 64'(busy_o), 64'd1);
    chk("drain_run", 64'(running_o), 64'd0);
    step(0, 0, 1, 16'd55, 1);
    chk("drain_novld", 64'(trig_time_valid_o), 64'd0);
    step(0, 0, 0, '0, 1);
    step(0, 0, 0, '0, 0);
    chk("drain_idle", 64'(busy_o), 64'd0);

    // Underflow set and clear on start.
    step(0, 0, 0, '0, 1);
    chk("uf_set", 64'(underflow_o), 64'd1);
    chk("uf_occ", 64'(occupancy_o), 64'd0);
    step(1, 0, 0, '0, 0);
    chk("uf_clr", 64'(underflow_o), 64'd0);

    // Reset in the middle of a run.
    idle(5);
    step(0, 0, 1, 16'hBEEF, 0);
    do_reset();
    chk("midrst_vld", 64'(trig_time_valid_o), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 699) == 0) do_reset();
      else step($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0,
                $urandom_range(0, 3) == 0, TIME_W'($urandom),
                $urandom_range(0, 6) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pueo_trig_scheduler.md
# pueo_trig_scheduler

Run and trigger sequencer for the PUEO capture datapath in the ifclk domain. Sequences run start and stop, emits the datapath run reset, and gates incoming trigger requests against event-buffer occupancy and a holdoff window. Forwards accepted triggers as aligned `trig_time`/`trig_time_valid` toward `pueo_wrapper`, and tracks readout completion to free buffers. Sits between run control / trigger logic and `pueo_wrapper`; CDC to aclk lives downstream and is not part of this block.

## Interface
Parameters:
- `NBUF`, default 4: number of event buffers in the datapath; max outstanding triggers.
- `HOLDOFF`, default 16: minimum ifclk cycles between accepted triggers.
- `TIME_W`, default 16: trigger time width.

Ports:
- `ifclk_i`  in  1: sole clock.
- `ifclk_rst_i`  in  1: reset, synchronous, active-high.
- `run_start_i`  in  1: one-cycle start request.
- `run_stop_i`  in  1: one-cycle stop request.
- `run_rst_o`  out  1: datapath run reset.
- `running_o`  out  1: high in state RUN.
- `busy_o`  out  1: high in any state other than IDLE.
- `trig_req_time_i`  in  TIME_W: requested trigger time.
- `trig_req_valid_i`  in  1: one-cycle trigger request.
- `trig_time_o`  out  TIME_W: accepted trigger time, 4-aligned.
- `trig_time_valid_o`  out  1: one-cycle strobe.
- `readout_done_i`  in  1: one event fully read out; frees a buffer.
- `occupancy_o`  out  $clog2(NBUF+1): outstanding events.
- `event_count_o`  out  32: accepted triggers this run; wraps.
- `drop_count_o`  out  16: rejected triggers this run; saturates at 16'hFFFF.
- `underflow_o`  out  1: sticky; `readout_done_i` seen with occupancy 0.

## Operation
- States: IDLE, RST, RUN, DRAIN.
- IDLE -> RST on `run_start_i`.
  - Entering RST clears `event_count_o`, `drop_count_o` and `underflow_o`.
  - Occupancy is not cleared.
- RST: `run_rst_o` high for exactly RST_LEN = 4 cycles, then -> RUN.
- RUN -> DRAIN on `run_stop_i`.
- DRAIN -> IDLE when occupancy == 0. A stop with occupancy already 0 still passes through DRAIN for one cycle.
- `run_start_i` outside IDLE is ignored. `run_stop_i` outside RUN is ignored.
- Trigger acceptance happens in RUN only, when all of these hold:
  - `trig_req_valid_i` is high;
  - occupancy < NBUF;
  - the holdoff counter is 0.
- On acceptance:
  - `trig_time_o` = {time[TIME_W-1:2], 2'b00} (rounded down to a multiple of 4);
  - occupancy +1, `event_count_o` +1;
  - holdoff counter loads HOLDOFF-1 and decrements to 0.
- A request in RUN failing either gate increments `drop_count_o`. Requests in IDLE, RST or DRAIN are ignored and not counted.
- `readout_done_i` decrements occupancy in any state. A done with occupancy 0 leaves occupancy at 0 and sets `underflow_o`.
- Accept and done in the same cycle: occupancy unchanged.

## Timing
- Reset values: state IDLE, all outputs 0, holdoff counter 0.
- `ifclk_rst_i` mid-run forces IDLE immediately. `run_rst_o` is not pulsed and no further `trig_time_valid_o` is issued.
- `run_rst_o` rises on the cycle after the `run_start_i` cycle. `running_o` rises on the cycle after `run_rst_o` falls.
- Trigger latency: `trig_time_valid_o` and `trig_time_o` are registered and valid exactly 1 cycle after the accepting `trig_req_valid_i`.
- `trig_time_o` holds its value until the next acceptance.
- Occupancy and both counters are registered and update on the same edge as `trig_time_valid_o`.
- Holdoff: after an acceptance at cycle t, the earliest next acceptance is cycle t+HOLDOFF.
- `run_stop_i` coinciding with a trigger request: the trigger is evaluated in RUN and may be accepted; the state then moves to DRAIN.

## Configuration
- `PUEO_SCHED_HOLDOFF_EN` defined: the holdoff gate is active as described above.
- `PUEO_SCHED_HOLDOFF_EN` undefined: the holdoff counter is not built, HOLDOFF is ignored, and only occupancy gates triggers (back-to-back acceptance allowed).

## Structure
- Package `pueo_sched_pkg` holds:
  - the state enum (IDLE, RST, RUN, DRAIN);
  - `RST_LEN` = 4;
  - `EVCNT_W` = 32;
  - `DROPCNT_W` = 16.
- Sub-module `pueo_buf_tracker` owns the up/down occupancy counter, full/empty flags and underflow detection. The top level owns the state machine, holdoff and the event/drop counters.

## Test plan
- Reset then `run_start_i` -> `run_rst_o` high for 4 cycles starting on the next cycle; `running_o` rises the following cycle; counters read 0.
- RUN, request time 14 -> one cycle later `trig_time_valid_o`=1, `trig_time_o`=12, occupancy 1, `event_count_o`=1.
- HOLDOFF=16 (macro on), requests at t and t+15, then t+16 -> second request dropped (`drop_count_o`=1); t+16 accepted. With the macro off, all three are accepted.
- NBUF=4, five spaced requests with no done -> 4 accepted, 1 dropped, occupancy 4. Then accept+done in the same cycle at occupancy 3 -> occupancy stays 3.
- Occupancy 2, `run_stop_i` -> DRAIN, `busy_o`=1; two `readout_done_i` -> IDLE; a trigger request during DRAIN produces no strobe and no drop count.
- `readout_done_i` at occupancy 0 -> `underflow_o`=1 and occupancy 0; a subsequent `run_start_i` clears `underflow_o`. `ifclk_rst_i` during RUN -> IDLE and all outputs 0 next cycle.
